// File: rtl/order_tx_serializer_pkg.sv
// Shared definitions for the order transmit serializer: message geometry,
// the add-order message type byte and the transmit FSM state encoding.
package order_tx_serializer_pkg;

  localparam int MSG_WORDS  = 9;
  localparam int PAIR_WORDS = 2 * MSG_WORDS;

  localparam logic [7:0] MSG_TYPE_ADD = 8'h41;

  localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_BUY  = 2'd1;
  localparam logic [1:0] ST_SEND_SELL = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    SEND_BUY  = ST_SEND_BUY,
    SEND_SELL = ST_SEND_SELL
  } state_e;

endpackage

// File: rtl/order_tx_serializer_if.sv
// Output word stream of the serializer: data, valid, last and the
// downstream ready, named from the serializer's point of view.
interface order_tx_serializer_if #(parameter int REG_WIDTH = 32);

  logic [REG_WIDTH-1:0] o_tdata;
  logic                 o_tvalid;
  logic                 o_tlast;
  logic                 i_tready;

  modport master (output o_tdata, output o_tvalid, output o_tlast, input i_tready);
  modport slave  (input o_tdata, input o_tvalid, input o_tlast, output i_tready);

endinterface

// File: rtl/order_tx_serializer_fifo.sv
// Frame-pair FIFO: each entry holds one buy message followed by one sell
// message. Pointers carry one extra wrap bit so full and empty differ.
module order_pair_fifo
  import order_tx_serializer_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_push,
  input  logic [PAIR_WORDS*REG_WIDTH-1:0]   i_wdata,
  input  logic                              i_pop,
  output logic [PAIR_WORDS*REG_WIDTH-1:0]   o_rdata,
  output logic                              o_empty,
  output logic                              o_full,
  output logic [$clog2(DEPTH):0]            o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WIDTH = PAIR_WORDS * REG_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Storage is written on accepted pushes only; its contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Pointers advance independently and wrap through the extra MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/order_tx_serializer.sv
// Captures buy/sell add-order frame pairs and streams each pair as nine buy
// words followed by nine sell words, with o_tlast on the last word of each.
module order_tx_serializer
  import order_tx_serializer_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [REG_WIDTH-1:0] i_reg_0_b, i_reg_1_b, i_reg_2_b,
  input  logic [REG_WIDTH-1:0] i_reg_3_b, i_reg_4_b, i_reg_5_b,
  input  logic [REG_WIDTH-1:0] i_reg_6_b, i_reg_7_b, i_reg_8_b,
  input  logic [REG_WIDTH-1:0] i_reg_0_s, i_reg_1_s, i_reg_2_s,
  input  logic [REG_WIDTH-1:0] i_reg_3_s, i_reg_4_s, i_reg_5_s,
  input  logic [REG_WIDTH-1:0] i_reg_6_s, i_reg_7_s, i_reg_8_s,
  order_tx_serializer_if.master io_tx,
  output logic                 o_busy,
  output logic [15:0]          o_drop_count
);

  localparam int AW = $clog2(DEPTH);

  state_e                          r_state;
  logic [3:0]                      r_idx;
  logic [15:0]                     r_drop_count;

  logic [PAIR_WORDS*REG_WIDTH-1:0] w_wdata;
  logic [PAIR_WORDS*REG_WIDTH-1:0] w_rdata;
  logic [REG_WIDTH-1:0]            w_words [PAIR_WORDS];
  logic [AW:0]                     w_level;
  logic                            w_empty, w_full;
  logic                            w_hs, w_pop, w_push, w_drop, w_more;
  logic [4:0]                      w_sel;

  // Buy words occupy word slots 0..8 and sell words slots 9..17.
  assign w_wdata = {i_reg_8_s, i_reg_7_s, i_reg_6_s, i_reg_5_s, i_reg_4_s,
                    i_reg_3_s, i_reg_2_s, i_reg_1_s, i_reg_0_s,
                    i_reg_8_b, i_reg_7_b, i_reg_6_b, i_reg_5_b, i_reg_4_b,
                    i_reg_3_b, i_reg_2_b, i_reg_1_b, i_reg_0_b};

  order_pair_fifo #(.REG_WIDTH(REG_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  // A pop on the final sell word frees its slot in time for a same-cycle push.
  assign w_hs   = io_tx.o_tvalid && io_tx.i_tready;
  assign w_pop  = (r_state == SEND_SELL) && w_hs && (r_idx == LAST_IDX);
  assign w_push = i_valid && (!w_full || w_pop);
  assign w_drop = i_valid && w_full && !w_pop;
  assign w_more = (w_level > (AW+1)'(1)) || w_push;

  // Split the head entry into individual stream words.
  always_comb begin
    for (int k = 0; k < PAIR_WORDS; k++) begin
      w_words[k] = w_rdata[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign w_sel = (r_state == SEND_SELL) ? (5'(r_idx) + 5'(MSG_WORDS)) : 5'(r_idx);

  // Transmit FSM walks the head pair word by word, advancing only on handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state <= SEND_BUY;
            r_idx   <= '0;
          end
        end
        SEND_BUY: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state <= SEND_SELL;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        SEND_SELL: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state <= w_more ? SEND_BUY : IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Count pairs refused because the buffer was full, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign io_tx.o_tvalid = (r_state != IDLE);
  assign io_tx.o_tlast  = (r_state != IDLE) && (r_idx == LAST_IDX);
  assign io_tx.o_tdata  = (r_state == IDLE) ? '0 : w_words[w_sel];
  assign o_busy         = !w_empty || (r_state != IDLE);
  assign o_drop_count   = r_drop_count;

endmodule

// File: tb/tb_order_tx_serializer.sv
// Bench for order_tx_serializer: randomized frame pairs, a word-queue model
// of the expected stream, plus directed latency, stall, drop and reset steps.
module tb_order_tx_serializer;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        endPair;
  } expWord_t;

  logic        clk;
  logic        rstN;
  logic        validIn;
  logic [31:0] buyW  [9];
  logic [31:0] sellW [9];
  logic        busy;
  logic [15:0] dropCount;

  int          checks = 0;
  int          failures = 0;
  int          hsCount = 0;
  int          accepted = 0;
  int          completed = 0;
  logic [15:0] modelDrops = '0;
  expWord_t    expQ [$];
  logic [31:0] p1Sell8, p2Buy0;

  order_tx_serializer_if #(.REG_WIDTH(32)) txIf ();

  order_tx_serializer #(.REG_WIDTH(32), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_valid      (validIn),
    .i_reg_0_b    (buyW[0]),  .i_reg_1_b (buyW[1]),  .i_reg_2_b (buyW[2]),
    .i_reg_3_b    (buyW[3]),  .i_reg_4_b (buyW[4]),  .i_reg_5_b (buyW[5]),
    .i_reg_6_b    (buyW[6]),  .i_reg_7_b (buyW[7]),  .i_reg_8_b (buyW[8]),
    .i_reg_0_s    (sellW[0]), .i_reg_1_s (sellW[1]), .i_reg_2_s (sellW[2]),
    .i_reg_3_s    (sellW[3]), .i_reg_4_s (sellW[4]), .i_reg_5_s (sellW[5]),
    .i_reg_6_s    (sellW[6]), .i_reg_7_s (sellW[7]), .i_reg_8_s (sellW[8]),
    .io_tx        (txIf),
    .o_busy       (busy),
    .o_drop_count (dropCount)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the coming edge, then return just after that edge.
  task automatic applyStimulus(input logic v, input logic r);
    validIn = v;
    txIf.i_tready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic randomPair();
    for (int k = 0; k < 9; k++) begin
      buyW[k]  = $urandom();
      sellW[k] = $urandom();
    end
  endtask

  task automatic drainWords(input int want, input bit toggle, input int maxCycles, input string tag);
    int startHs;
    int n;
    startHs = hsCount;
    n = 0;
    while (((hsCount - startHs) < want) && (n < maxCycles)) begin
      applyStimulus(1'b0, toggle ? ((n % 2) == 0) : 1'b1);
      n++;
    end
    checkOutput(tag, 32'(hsCount - startHs), 32'(want));
    checkOutput({tag, "_tvalid_after"}, 32'(txIf.o_tvalid), 32'd0);
  endtask

  // Model: accepted pairs become 18 expected words; a pair is accepted when
  // fewer than DEPTH pairs are still unfinished after this edge's handshake.
  task automatic monitorLoop();
    expWord_t w;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        expQ.delete();
        accepted = 0;
        completed = 0;
        modelDrops = '0;
      end else begin
        checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
        checkOutput("drop_count", 32'(dropCount), 32'(modelDrops));
        if (txIf.o_tvalid) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_word observed=%0h expected=none", txIf.o_tdata);
          end else begin
            checkOutput("tdata", txIf.o_tdata, expQ[0].data);
            checkOutput("tlast", 32'(txIf.o_tlast), 32'(expQ[0].last));
            if (txIf.i_tready) begin
              hsCount++;
              if (expQ[0].endPair) completed++;
              void'(expQ.pop_front());
            end
          end
        end else begin
          checkOutput("idle_tdata", txIf.o_tdata, 32'd0);
          checkOutput("idle_tlast", 32'(txIf.o_tlast), 32'd0);
        end
        if (validIn) begin
          if ((accepted - completed) < DEPTH) begin
            for (int k = 0; k < 18; k++) begin
              w.data    = (k < 9) ? buyW[k] : sellW[k-9];
              w.last    = (k == 8) || (k == 17);
              w.endPair = (k == 17);
              expQ.push_back(w);
            end
            accepted++;
          end else if (modelDrops != 16'hFFFF) begin
            modelDrops = modelDrops + 16'd1;
          end
        end
      end
    end
  endtask

  initial begin
    rstN = 1'b0;
    validIn = 1'b0;
    txIf.i_tready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      buyW[k] = '0;
      sellW[k] = '0;
    end
    fork
      monitorLoop();
      begin
        // Reset state
        #2;
        checkOutput("rst_tvalid", 32'(txIf.o_tvalid), 32'd0);
        checkOutput("rst_tdata", txIf.o_tdata, 32'd0);
        checkOutput("rst_tlast", 32'(txIf.o_tlast), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_drop", 32'(dropCount), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(1'b0, 1'b1);

        // Single pair with known words, ready held high
        $display("[TB] single pair, ready high");
        for (int k = 0; k < 9; k++) begin
          buyW[k]  = 32'hB0 + 32'(k);
          sellW[k] = 32'h50 + 32'(k);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("lat_tvalid_n", 32'(txIf.o_tvalid), 32'd0);
        checkOutput("lat_busy_n", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lat_tvalid_n1", 32'(txIf.o_tvalid), 32'd1);
        checkOutput("lat_tdata_n1", txIf.o_tdata, 32'hB0);
        drainWords(18, 1'b0, 18, "single_pair_words");

        // Ready toggling every cycle
        $display("[TB] ready toggling");
        randomPair();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        drainWords(18, 1'b1, 60, "toggle_words");

        // Three strobes into a stalled two-deep buffer
        $display("[TB] overflow with ready low");
        randomPair();
        applyStimulus(1'b1, 1'b0);
        randomPair();
        applyStimulus(1'b1, 1'b0);
        randomPair();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("overflow_drop", 32'(dropCount), 32'd1);
        drainWords(36, 1'b0, 80, "overflow_words");

        // Push coinciding with the final sell word while full
        $display("[TB] push during final sell handshake");
        randomPair();
        p1Sell8 = sellW[8];
        applyStimulus(1'b1, 1'b0);
        randomPair();
        p2Buy0 = buyW[0];
        applyStimulus(1'b1, 1'b0);
        repeat (17) applyStimulus(1'b0, 1'b1);
        checkOutput("coincide_pre_tdata", txIf.o_tdata, p1Sell8);
        checkOutput("coincide_pre_tlast", 32'(txIf.o_tlast), 32'd1);
        randomPair();
        applyStimulus(1'b1, 1'b1);
        checkOutput("coincide_drop", 32'(dropCount), 32'd1);
        checkOutput("coincide_tvalid", 32'(txIf.o_tvalid), 32'd1);
        checkOutput("coincide_next_tdata", txIf.o_tdata, p2Buy0);
        drainWords(36, 1'b0, 80, "coincide_words");

        // Asynchronous reset in the middle of a buy message
        $display("[TB] reset mid-message");
        randomPair();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        checkOutput("midrst_word4", txIf.o_tdata, buyW[4]);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrst_tvalid", 32'(txIf.o_tvalid), 32'd0);
        checkOutput("midrst_tdata", txIf.o_tdata, 32'd0);
        checkOutput("midrst_tlast", 32'(txIf.o_tlast), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_drop", 32'(dropCount), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (10) applyStimulus(1'b0, 1'b1);
        checkOutput("postrst_tvalid", 32'(txIf.o_tvalid), 32'd0);
        checkOutput("postrst_busy", 32'(busy), 32'd0);

        // Drop counter saturation
        $display("[TB] drop counter saturation");
        randomPair();
        repeat (2 + 65540) applyStimulus(1'b1, 1'b0);
        checkOutput("sat_drop", 32'(dropCount), 32'h0000FFFF);
        drainWords(36, 1'b0, 100, "sat_words");
        checkOutput("model_empty", 32'(expQ.size()), 32'd0);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/order_tx_serializer.md
ORDER_TX_SERIALIZER -- requirements
Module: order_tx_serializer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, word width of captured registers and output stream.
REQ-002 SHALL have parameter DEPTH, default 2, number of buy/sell frame pairs buffered (power of two, >=2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  single-cycle strobe: frame pair present on i_reg_*.
REQ-007 i_reg_0_b .. i_reg_8_b  input  REG_WIDTH each  buy-side add-order words 0..8.
REQ-008 i_reg_0_s .. i_reg_8_s  input  REG_WIDTH each  sell-side add-order words 0..8.
REQ-009 o_tdata  output  REG_WIDTH  stream word.
REQ-010 o_tvalid  output  1  stream word valid.
REQ-011 i_tready  input  1  downstream ready.
REQ-012 o_tlast  output  1  last word (word 8) of a message.
REQ-013 o_busy  output  1  buffer non-empty or message in flight.
REQ-014 o_drop_count  output  16  frame pairs dropped due to full buffer.

Function
REQ-015 SHALL capture all 18 input words into a DEPTH-entry frame-pair FIFO on a rising edge where i_valid=1 and FIFO not full.
REQ-016 SHALL, when i_valid=1 and FIFO full, discard the pair and increment o_drop_count, saturating at 16'hFFFF.
REQ-017 FIFO full SHALL be evaluated after same-cycle pop: if the final sell word handshakes in the cycle i_valid=1 with FIFO full, the new pair SHALL be accepted, not dropped.
REQ-018 SHALL use FSM states IDLE, SEND_BUY, SEND_SELL; 4-bit word index 0..8.
REQ-019 IDLE -> SEND_BUY when FIFO non-empty; index=0.
REQ-020 SEND_BUY: present buy word[index]; on o_tvalid&&i_tready, index+1; at index 8 handshake -> SEND_SELL, index=0.
REQ-021 SEND_SELL: present sell word[index]; at index 8 handshake pop FIFO -> SEND_BUY if FIFO still non-empty (including same-cycle push), else IDLE.
REQ-022 o_tlast SHALL be 1 exactly when index=8 in SEND_BUY or SEND_SELL.
REQ-023 o_tvalid SHALL be 1 in SEND_BUY/SEND_SELL, 0 in IDLE; o_tdata=0 in IDLE.
REQ-024 While o_tvalid=1 and i_tready=0, o_tdata, o_tlast, o_tvalid SHALL hold stable.
REQ-025 Latency: i_valid at edge N into empty FIFO, IDLE -> o_tvalid=1 with buy word 0 after edge N+1.
REQ-026 With i_tready held 1, a pair SHALL stream in 18 consecutive cycles; back-to-back pairs with no idle gap.
REQ-027 FIFO read/write pointers SHALL be log2(DEPTH)+1 bits, wrapping naturally; full = MSBs differ, lower bits equal.
REQ-028 o_busy = (FIFO non-empty) or (state != IDLE).

Reset
REQ-029 i_rst_n=0 SHALL immediately force state IDLE, index 0, pointers 0, o_tvalid 0, o_tlast 0, o_tdata 0, o_busy 0, o_drop_count 0.
REQ-030 Reset mid-message SHALL abandon the message; no partial resumption after release.
REQ-031 FIFO storage SHALL need no reset.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, MSG_WORDS=9, and message-type byte 8'h41.
REQ-033 FIFO storage/pointers SHALL be sub-module order_pair_fifo (2*9*REG_WIDTH wide, DEPTH deep); FSM and mux stay in top.

Verification
REQ-034 One pair, buy words 32'hB0..B8, sell 32'h50..58, i_tready=1 -> 18 words B0..B8,50..58, o_tlast on B8 and 58, o_tvalid from N+1.
REQ-035 i_tready toggling 1,0 each cycle -> same 18 words in order, each held while stalled, no duplicates.
REQ-036 Three i_valid strobes in consecutive cycles, i_tready=0, DEPTH=2 -> o_drop_count=1; after release, exactly 36 words from first two pairs.
REQ-037 FIFO full, i_valid coincides with final sell-word handshake -> pair accepted, o_drop_count unchanged, next buy word 0 follows next cycle.
REQ-038 Assert i_rst_n=0 at buy word 4 -> outputs 0 asynchronously; after release with no i_valid, o_tvalid stays 0.
REQ-039 Force 65540 drops -> o_drop_count=16'hFFFF.
